pm_rate_monitor: RTL

PM_RATE_MONITOR -- requirements
Module: pm_rate_monitor

---
 rtl/pm_rate_monitor.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/pm_rate_monitor.sv
// pm_rate_monitor
//   Measures the rate and spacing of a frame-start strobe over fixed windows
//   of WINDOW_CYCLES clocks. The first strobe seen after enabling opens
//   window 0; windows then follow back to back. At the end of each window the
//   event count, the smallest and largest inter-event gap and the rate/overflow
//   flags are registered and result_valid pulses for one cycle.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   enable        1 = monitor runs, 0 = return to IDLE (partial window dropped)
//   input_sig     frame-start strobe, one event per high cycle
//   frame_count   events in the last published window
//   min_gap       smallest gap in the last window (all-ones when none)
//   max_gap       largest gap in the last window (0 when none)
//   result_valid  one-cycle pulse when new results are published
//   rate_low      frame_count < EXPECTED_MIN
//   rate_high     frame_count > EXPECTED_MAX
//   gap_overflow  a gap saturated in the last window
//   dbg_state     current FSM state (0 IDLE, 1 WAIT_FIRST, 2 MEASURE)
//
// Handshake: result_valid is a qualifier only; there is no ready. The outputs
// change only on the cycle result_valid is high and hold otherwise.
module pm_rate_monitor #(
    parameter int WINDOW_CYCLES = 100,
    parameter int EXPECTED_MIN  = 9,
    parameter int EXPECTED_MAX  = 11,
    parameter int GAP_WIDTH     = 8,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   input_sig,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [GAP_WIDTH-1:0]   min_gap,
    output logic [GAP_WIDTH-1:0]   max_gap,
    output logic                   result_valid,
    output logic                   rate_low,
    output logic                   rate_high,
    output logic                   gap_overflow,
    output logic [1:0]             dbg_state
);

    localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0]       WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [GAP_WIDTH-1:0]   GAP_MAX  = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
    logic [COUNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [GAP_WIDTH-1:0]   run_min_q, run_min_d;
    logic [GAP_WIDTH-1:0]   run_max_q, run_max_d;
    logic                   run_ovf_q, run_ovf_d;

    logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
    logic [GAP_WIDTH-1:0]   min_gap_q, min_gap_d;
    logic [GAP_WIDTH-1:0]   max_gap_q, max_gap_d;
    logic                   result_valid_q, result_valid_d;
    logic                   rate_low_q, rate_low_d;
    logic                   rate_high_q, rate_high_d;
    logic                   gap_overflow_q, gap_overflow_d;

    // Saturating increments. gap_inc is also the gap recorded when an event
    // lands this cycle (gap = cycles since last event = counter + 1).
    logic [GAP_WIDTH-1:0]   gap_inc;
    logic [COUNT_WIDTH-1:0] cnt_inc;

    // Window statistics with this cycle's event folded in, so an event on the
    // last window cycle is part of the published result.
    logic [COUNT_WIDTH-1:0] m_cnt;
    logic [GAP_WIDTH-1:0]   m_min;
    logic [GAP_WIDTH-1:0]   m_max;
    logic                   m_ovf;

    assign gap_inc = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;
    assign cnt_inc = (evt_cnt_q == CNT_MAX) ? evt_cnt_q : evt_cnt_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        win_cnt_d      = win_cnt_q;
        evt_cnt_d      = evt_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        run_min_d      = run_min_q;
        run_max_d      = run_max_q;
        run_ovf_d      = run_ovf_q;
        frame_count_d  = frame_count_q;
        min_gap_d      = min_gap_q;
        max_gap_d      = max_gap_q;
        result_valid_d = 1'b0;
        rate_low_d     = rate_low_q;
        rate_high_d    = rate_high_q;
        gap_overflow_d = gap_overflow_q;
        m_cnt          = evt_cnt_q;
        m_min          = run_min_q;
        m_max          = run_max_q;
        m_ovf          = run_ovf_q;

        if (!enable) begin
            // Drop any partial window; published outputs are left untouched.
            state_d   = IDLE;
            win_cnt_d = '0;
            evt_cnt_d = '0;
            gap_cnt_d = '0;
            run_min_d = GAP_MAX;
            run_max_d = '0;
            run_ovf_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_FIRST;
                end

                WAIT_FIRST: begin
                    if (input_sig) begin
                        // This cycle is window cycle 0 and holds event #1.
                        state_d   = MEASURE;
                        win_cnt_d = WIN_W'(1);
                        evt_cnt_d = COUNT_WIDTH'(1);
                        gap_cnt_d = '0;
                        run_min_d = GAP_MAX;
                        run_max_d = '0;
                        run_ovf_d = 1'b0;
                    end
                end

                MEASURE: begin
                    if (input_sig) begin
                        m_cnt = cnt_inc;
                        if (gap_inc < run_min_q) m_min = gap_inc;
                        if (gap_inc > run_max_q) m_max = gap_inc;
                        if (gap_inc == GAP_MAX) m_ovf = 1'b1;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_inc;
                    end

                    if (win_cnt_q == WIN_LAST) begin
                        frame_count_d  = m_cnt;
                        min_gap_d      = m_min;
                        max_gap_d      = m_max;
                        gap_overflow_d = m_ovf;
                        rate_low_d     = (m_cnt < COUNT_WIDTH'(EXPECTED_MIN));
                        rate_high_d    = (m_cnt > COUNT_WIDTH'(EXPECTED_MAX));
                        result_valid_d = 1'b1;
                        // Next window starts immediately. The gap counter keeps
                        // running so a boundary-spanning gap lands where it ends.
                        win_cnt_d      = '0;
                        evt_cnt_d      = '0;
                        run_min_d      = GAP_MAX;
                        run_max_d      = '0;
                        run_ovf_d      = 1'b0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        evt_cnt_d = m_cnt;
                        run_min_d = m_min;
                        run_max_d = m_max;
                        run_ovf_d = m_ovf;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            win_cnt_q      <= '0;
            evt_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            run_min_q      <= GAP_MAX;
            run_max_q      <= '0;
            run_ovf_q      <= 1'b0;
            frame_count_q  <= '0;
            min_gap_q      <= GAP_MAX;
            max_gap_q      <= '0;
            result_valid_q <= 1'b0;
            rate_low_q     <= 1'b0;
            rate_high_q    <= 1'b0;
            gap_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            win_cnt_q      <= win_cnt_d;
            evt_cnt_q      <= evt_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            run_min_q      <= run_min_d;
            run_max_q      <= run_max_d;
            run_ovf_q      <= run_ovf_d;
            frame_count_q  <= frame_count_d;
            min_gap_q      <= min_gap_d;
            max_gap_q      <= max_gap_d;
            result_valid_q <= result_valid_d;
            rate_low_q     <= rate_low_d;
            rate_high_q    <= rate_high_d;
            gap_overflow_q <= gap_overflow_d;
        end
    end

    assign frame_count  = frame_count_q;
    assign min_gap      = min_gap_q;
    assign max_gap      = max_gap_q;
    assign result_valid = result_valid_q;
    assign rate_low     = rate_low_q;
    assign rate_high    = rate_high_q;
    assign gap_overflow = gap_overflow_q;
    assign dbg_state    = state_q;

endmodule
